// File: rtl/pbkdf2_pkg.sv
// Shared types and field layout for the PBKDF2 iteration stage.
package pbkdf2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  // msg_len code for a 32-byte message (length-minus-one encoding)
  localparam logic [4:0] MSG_LEN_U = 5'd31;

  localparam int unsigned KEY_LSB  = 512;
  localparam int unsigned MSG_W    = 512;
  localparam int unsigned DIGEST_W = 256;

endpackage

// File: rtl/pbkdf2_iter_accum.sv
// PBKDF2 iteration stage: drives hmac_sha256 c times, XOR-accumulating T = U_1 ^ ... ^ U_c.
// Optional macro PBKDF2_ITER_PROGRESS_EN adds the iter_done_o progress counter.
module pbkdf2_iter_accum
  import pbkdf2_pkg::*;
#(
  parameter int unsigned ITER_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_v_i,
  output logic                in_ready_o,
  input  logic [1023:0]       in_data_i,
  input  logic [4:0]          in_len_i,
  input  logic [ITER_W-1:0]   iter_i,
  output logic                hmac_v_o,
  input  logic                hmac_ready_i,
  output logic [1023:0]       hmac_data_o,
  output logic [4:0]          hmac_len_o,
  input  logic                hmac_v_i,
  input  logic [255:0]        hmac_data_i,
  output logic                hmac_yumi_o,
`ifdef PBKDF2_ITER_PROGRESS_EN
  output logic [ITER_W-1:0]   iter_done_o,
`endif
  output logic                out_v_o,
  output logic [255:0]        out_data_o,
  input  logic                out_ready_i
);

  state_t                state, state_nxt;
  logic [MSG_W-1:0]      key;
  logic [MSG_W-1:0]      msg0;
  logic [4:0]            len0;
  logic [ITER_W-1:0]     c;
  logic [ITER_W-1:0]     k;
  logic [DIGEST_W-1:0]   t;
  logic [DIGEST_W-1:0]   u_prev;
  logic                  accept;
  logic                  first;

  assign accept = in_v_i & in_ready_o;
  assign first  = (k == ITER_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      key    <= '0;
      msg0   <= '0;
      len0   <= '0;
      c      <= '0;
      k      <= '0;
      t      <= '0;
      u_prev <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        key  <= in_data_i[1023:KEY_LSB];
        msg0 <= in_data_i[MSG_W-1:0];
        len0 <= in_len_i;
        c    <= (iter_i == '0) ? ITER_W'(1) : iter_i;
        k    <= ITER_W'(1);
        t    <= '0;
      end
      // k stops at c, so c = all-ones never wraps the counter
      if (hmac_yumi_o) begin
        t      <= t ^ hmac_data_i;
        u_prev <= hmac_data_i;
        if (k != c) begin
          k <= k + ITER_W'(1);
        end
      end
    end
  end

`ifdef PBKDF2_ITER_PROGRESS_EN
  logic [ITER_W-1:0] done_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_cnt <= '0;
    end else if (accept) begin
      done_cnt <= '0;
    end else if (hmac_yumi_o) begin
      done_cnt <= done_cnt + ITER_W'(1);
    end
  end

  assign iter_done_o = done_cnt;
`endif

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    hmac_v_o    = 1'b0;
    hmac_data_o = '0;
    hmac_len_o  = '0;
    hmac_yumi_o = 1'b0;
    out_v_o     = 1'b0;
    out_data_o  = t;
    unique case (state)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_v_i) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        hmac_v_o = 1'b1;
        if (first) begin
          hmac_data_o = {key, msg0};
          hmac_len_o  = len0;
        end else begin
          hmac_data_o = {key, {(MSG_W-DIGEST_W){1'b0}}, u_prev};
          hmac_len_o  = MSG_LEN_U;
        end
        if (hmac_ready_i) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        hmac_yumi_o = hmac_v_i;
        if (hmac_v_i) begin
          state_nxt = (k == c) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        out_v_o = 1'b1;
        if (out_ready_i) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pbkdf2_iter_accum.sv
// Scoreboard bench for pbkdf2_iter_accum with a stand-in keyed-hash responder.
module tb_pbkdf2_iter_accum;
  import pbkdf2_pkg::*;

  localparam int unsigned ITER_W = 32;

  logic               clk = 1'b0;
  logic               rst_i = 1'b1;
  logic               in_v_i = 1'b0;
  logic               in_ready_o;
  logic [1023:0]      in_data_i = '0;
  logic [4:0]         in_len_i = '0;
  logic [ITER_W-1:0]  iter_i = '0;
  logic               hmac_v_o;
  logic               hmac_ready_i = 1'b0;
  logic [1023:0]      hmac_data_o;
  logic [4:0]         hmac_len_o;
  logic               hmac_v_i = 1'b0;
  logic [255:0]       hmac_data_i = '0;
  logic               hmac_yumi_o;
  logic               out_v_o;
  logic [255:0]       out_data_o;
  logic               out_ready_i = 1'b0;
`ifdef PBKDF2_ITER_PROGRESS_EN
  logic [ITER_W-1:0]  iter_done_o;
`endif

  pbkdf2_iter_accum #(.ITER_W(ITER_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .in_v_i       (in_v_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .in_len_i     (in_len_i),
    .iter_i       (iter_i),
    .hmac_v_o     (hmac_v_o),
    .hmac_ready_i (hmac_ready_i),
    .hmac_data_o  (hmac_data_o),
    .hmac_len_o   (hmac_len_o),
    .hmac_v_i     (hmac_v_i),
    .hmac_data_i  (hmac_data_i),
    .hmac_yumi_o  (hmac_yumi_o),
`ifdef PBKDF2_ITER_PROGRESS_EN
    .iter_done_o  (iter_done_o),
`endif
    .out_v_o      (out_v_o),
    .out_data_o   (out_data_o),
    .out_ready_i  (out_ready_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1023:0] d;
    logic [4:0]    l;
  } req_t;

  req_t          req_q[$];
  logic [255:0]  exp_t_q[$];
  logic [31:0]   exp_n_q[$];
  logic          hold_low = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in for hmac_sha256: any deterministic keyed mix of (data, len) exercises the datapath.
  function automatic logic [255:0] mix(input logic [1023:0] d, input logic [4:0] l);
    logic [255:0] h;
    h = {8{32'h6a09e667 ^ {27'd0, l}}};
    for (int i = 0; i < 32; i++) begin
      h = {h[218:0], h[255:219]};
      h[31:0] = (h[31:0] * 32'h01000193) ^ d[i*32 +: 32];
      h[255:224] = h[255:224] ^ h[31:0];
    end
    return h;
  endfunction

  // PBKDF2 reference: U_1 = H(key, msg0), U_i = H(key, U_{i-1}), T = xor of all U
  task automatic model(input logic [511:0] key, input logic [511:0] msg0,
                       input logic [4:0] len0, input logic [31:0] iter);
    logic [31:0]   c;
    logic [255:0]  u;
    logic [255:0]  t;
    logic [1023:0] d;
    c = (iter == 0) ? 32'd1 : iter;
    d = {key, msg0};
    req_q.push_back('{d: d, l: len0});
    u = mix(d, len0);
    t = u;
    for (int unsigned i = 2; i <= c; i++) begin
      d = {key, 256'd0, u};
      req_q.push_back('{d: d, l: MSG_LEN_U});
      u = mix(d, MSG_LEN_U);
      t = t ^ u;
    end
    exp_t_q.push_back(t);
    exp_n_q.push_back(c);
  endtask

  // Handshakes as the DUT saw them at the rising edge
  logic          req_hs = 1'b0, dig_hs = 1'b0, out_hs = 1'b0;
  logic [1023:0] req_d = '0;
  logic [4:0]    req_l = '0;
  logic [255:0]  out_d = '0;
  int            req_seen = 0;

  always @(posedge clk) begin
    if (rst_i) begin
      req_hs <= 1'b0;
      dig_hs <= 1'b0;
      out_hs <= 1'b0;
    end else begin
      req_hs <= hmac_v_o & hmac_ready_i;
      req_d  <= hmac_data_o;
      req_l  <= hmac_len_o;
      dig_hs <= hmac_v_i & hmac_yumi_o;
      out_hs <= out_v_o & out_ready_i;
      out_d  <= out_data_o;
      if (hmac_v_o && hmac_ready_i) req_seen <= req_seen + 1;
    end
  end

  // Hash responder with random latency and random request backpressure
  logic busy = 1'b0;
  int   lat = 0;

  always @(negedge clk) begin
    if (rst_i) begin
      busy = 1'b0;
      hmac_v_i = 1'b0;
      hmac_ready_i = 1'b0;
    end else begin
      if (hmac_yumi_o) chk("yumi_only_with_valid", {255'd0, hmac_v_i}, 256'd1);
      if (dig_hs) begin
        busy = 1'b0;
        hmac_v_i = 1'b0;
      end
      if (req_hs) begin
        if (req_q.size() == 0) begin
          chk("unexpected_hmac_request", 256'd1, 256'd0);
        end else begin
          req_t r;
          r = req_q.pop_front();
          chk("hmac_req_data_hash", mix(req_d, 5'd0), mix(r.d, 5'd0));
          chk("hmac_req_len", {251'd0, req_l}, {251'd0, r.l});
        end
        busy = 1'b1;
        lat = $urandom_range(0, 3);
        hmac_data_i = mix(req_d, req_l);
      end else if (busy && !hmac_v_i) begin
        if (lat == 0) hmac_v_i = 1'b1;
        else lat--;
      end
      hmac_ready_i = !busy && ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    out_ready_i = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Output monitor: pops the scoreboard on each T handshake and watches hold stability
  logic         prev_v = 1'b0;
  logic [255:0] prev_d = '0;

  always @(negedge clk) begin
    if (rst_i) begin
      prev_v = 1'b0;
    end else begin
      if (out_hs) begin
        if (exp_t_q.size() == 0) begin
          chk("unexpected_output", 256'd1, 256'd0);
        end else begin
          chk("t_value", out_d, exp_t_q.pop_front());
          void'(exp_n_q.pop_front());
        end
      end
      if (prev_v && !out_hs) begin
        chk("out_v_held", {255'd0, out_v_o}, 256'd1);
        chk("out_data_held", out_data_o, prev_d);
      end
      if (out_v_o) begin
        chk("in_ready_low_in_done", {255'd0, in_ready_o}, 256'd0);
`ifdef PBKDF2_ITER_PROGRESS_EN
        if (exp_n_q.size() != 0)
          chk("iter_done", {224'd0, iter_done_o}, {224'd0, exp_n_q[0]});
`endif
      end
      prev_v = out_v_o;
      prev_d = out_data_o;
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!in_ready_o && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) chk(name, 256'd0, 256'd1);
  endtask

  task automatic do_req(input logic [31:0] iter);
    logic [1023:0] d;
    logic [4:0]    l;
    wait_idle("timeout_waiting_in_ready");
    for (int i = 0; i < 32; i++) d[i*32 +: 32] = $urandom;
    l = 5'($urandom_range(0, 31));
    model(d[1023:512], d[511:0], l, iter);
    in_data_i = d;
    in_len_i  = l;
    iter_i    = iter;
    in_v_i    = 1'b1;
    @(negedge clk);
    in_v_i    = 1'b0;
    in_data_i = {32{$urandom}};
    iter_i    = $urandom;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_t_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (exp_t_q.size() != 0) chk(name, 256'd1, 256'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", {255'd0, in_ready_o}, 256'd1);
    chk("rst_hmac_v", {255'd0, hmac_v_o}, 256'd0);
    chk("rst_hmac_yumi", {255'd0, hmac_yumi_o}, 256'd0);
    chk("rst_out_v", {255'd0, out_v_o}, 256'd0);
    chk("rst_out_data", out_data_o, 256'd0);
    chk("rst_hmac_data", {255'd0, |hmac_data_o}, 256'd0);
    chk("rst_hmac_len", {251'd0, hmac_len_o}, 256'd0);
`ifdef PBKDF2_ITER_PROGRESS_EN
    chk("rst_iter_done", {224'd0, iter_done_o}, 256'd0);
`endif
  endtask

  initial begin
    logic [255:0] held;
    int base;
    int n;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_i = 1'b0;
    @(negedge clk);

    do_req(32'd1);
    do_req(32'd0);
    do_req(32'd2);
    for (int i = 0; i < 20; i++) do_req(32'($urandom_range(0, 6)));
    do_req(32'd300);
    drain("timeout_drain_random");

    // DONE held with out_ready low
    hold_low = 1'b1;
    do_req(32'd2);
    n = 0;
    while (!out_v_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached_done", {255'd0, out_v_o}, 256'd1);
    held = out_data_o;
    repeat (20) begin
      @(negedge clk);
      chk("hold_out_v", {255'd0, out_v_o}, 256'd1);
      chk("hold_out_data", out_data_o, held);
      chk("hold_in_ready", {255'd0, in_ready_o}, 256'd0);
    end
    hold_low = 1'b0;
    drain("timeout_drain_hold");

    // Reset while waiting on the third digest of c=8
    base = req_seen;
    do_req(32'd8);
    n = 0;
    while (req_seen < base + 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_third_request", 256'(req_seen - base), 256'd3);
    rst_i = 1'b1;
    #1;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    req_q.delete();
    exp_t_q.delete();
    exp_n_q.delete();
    rst_i = 1'b0;
    @(negedge clk);
    do_req(32'd1);
    drain("timeout_drain_after_reset");
    chk("no_leftover_requests", 256'(req_q.size()), 256'd0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
